// File: rtl/bcd2bin_seq_pkg.sv
// bcd2bin_seq_pkg: shared states, digit constants and counter sizing for the BCD-to-binary converter
package bcd2bin_seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [3:0] DIG_THRESH = 4'd8;
  localparam logic [3:0] DIG_ADJ = 4'd3;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/bcd2bin_seq_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble correction, subtracts 3 from a digit that is 8 or more
module bcd_digit_adjust
  import bcd2bin_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= DIG_THRESH) ? d - DIG_ADJ : d;
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter, one reverse double-dabble shift per clock
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int W  = 18,
  parameter int ND = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4*ND-1:0] bcd_in,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    bin,
  output logic            ovf,
  output logic            err
);
  localparam int CW = cnt_width(W);
  state_t state_q, state_d;
  logic [4*ND-1:0] digits_q, digits_d, load_dig, adj_dig;
  logic [W-1:0] acc_q, acc_d, bin_q, bin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_pend_q, err_pend_d, ovf_q, ovf_d, err_q, err_d, done_q, done_d, load_err;
  logic [4*ND+W-1:0] shifted;
  assign shifted = {digits_q, acc_q} >> 1;
  for (genvar g = 0; g < ND; g++) begin : g_adj
    bcd_digit_adjust u_adj (.d(shifted[W+4*g +: 4]), .q(adj_dig[4*g +: 4]));
  end
  always_comb begin
    load_dig = '0;
    load_err = 1'b0;
    for (int k = 0; k < ND; k++) begin
      load_dig[4*k +: 4] = (bcd_in[4*k +: 4] == BLANK_DIGIT) ? 4'd0 : bcd_in[4*k +: 4];
      load_err = load_err | (bcd_in[4*k +: 4] >= 4'hA && bcd_in[4*k +: 4] <= 4'hE);
    end
  end
  always_comb begin
    state_d = state_q;
    digits_d = digits_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    err_pend_d = err_pend_q;
    bin_d = bin_q;
    ovf_d = ovf_q;
    err_d = err_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        digits_d = load_dig;
        err_pend_d = load_err;
        acc_d = '0;
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        digits_d = adj_dig;
        acc_d = shifted[W-1:0];
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(W - 1)) ? FINISH : SHIFT;
      end
      FINISH: begin
        done_d = 1'b1;
        state_d = IDLE;
        err_d = err_pend_q;
        ovf_d = !err_pend_q && |digits_q;
        bin_d = err_pend_q ? '0 : (|digits_q ? '1 : acc_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      digits_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      err_pend_q <= 1'b0;
      bin_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_pend_q <= err_pend_d;
      bin_q <= bin_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bin = bin_q;
  assign ovf = ovf_q;
  assign err = err_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: table-driven and scoreboard checks for bcd2bin_seq
module tb_bcd2bin_seq;
  localparam int W = 18;
  localparam int ND = 6;
  typedef struct {logic [23:0] bcd; logic [17:0] bin; logic ovf; logic err;} vec_t;
  typedef struct {logic [17:0] bin; logic ovf; logic err;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [23:0] bcd_in = '0;
  logic busy, done, ovf, err;
  logic [17:0] bin;
  int pass_cnt = 0, total_cnt = 0;
  exp_t sb[$];
  vec_t vecs[10];
  bcd2bin_seq #(.W(W), .ND(ND)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin(bin), .ovf(ovf), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    x = v;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  task automatic issue(input logic [23:0] b, input logic [17:0] eb, input logic eo, input logic ee);
    exp_t e;
    e.bin = eb;
    e.ovf = eo;
    e.err = ee;
    bcd_in = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_check(input string nm, input int n0, input int b0);
    int n, bc;
    exp_t e;
    n = n0;
    bc = b0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end while (!done && n < 40);
    check({nm, "_latency"}, n, W + 2);
    check({nm, "_busy_cycles"}, bc, W + 1);
    e = sb.pop_front();
    check({nm, "_bin"}, bin, e.bin);
    check({nm, "_ovf"}, ovf, e.ovf);
    check({nm, "_err"}, err, e.err);
  endtask
  task automatic run(input string nm, input logic [23:0] b, input logic [17:0] eb, input logic eo, input logic ee);
    issue(b, eb, eo, ee);
    wait_check(nm, 0, 0);
  endtask
  initial begin
    vecs[0] = '{24'h000123, 18'd123, 1'b0, 1'b0};
    vecs[1] = '{24'hFFFF07, 18'd7, 1'b0, 1'b0};
    vecs[2] = '{24'h262143, 18'h3FFFF, 1'b0, 1'b0};
    vecs[3] = '{24'h262144, 18'h3FFFF, 1'b1, 1'b0};
    vecs[4] = '{24'h999999, 18'h3FFFF, 1'b1, 1'b0};
    vecs[5] = '{24'h00012A, 18'd0, 1'b0, 1'b1};
    vecs[6] = '{24'h000000, 18'd0, 1'b0, 1'b0};
    vecs[7] = '{24'hF0F0F1, 18'd1, 1'b0, 1'b0};
    vecs[8] = '{24'hB00000, 18'd0, 1'b0, 1'b1};
    vecs[9] = '{24'h100000, 18'd100000, 1'b0, 1'b0};
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bin", bin, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) run($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].ovf, vecs[i].err);
    repeat (3) @(negedge clk);
    check("done_one_cycle", done, 0);
    check("hold_bin", bin, 18'd100000);
    issue(24'h000456, 18'd456, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bcd_in = 24'h000789;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_check("ignore_start", 5, 5);
    @(negedge clk);
    bcd_in = 24'h000321;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bin", bin, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("after_rst", 24'h000321, 18'd321, 1'b0, 1'b0);
    run("rt_zero", to_bcd(0), 18'd0, 1'b0, 1'b0);
    run("rt_max", to_bcd(262143), 18'd262143, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      int v;
      v = int'($urandom_range(0, 262143));
      run($sformatf("rt%0d", i), to_bcd(v), 18'(v), 1'b0, 1'b0);
    end
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter, inverse of the team's combinational binary-to-BCD block.
- Converts a packed BCD word (keypad/display digits, leading digits possibly blanked as 4'hF) into an unsigned binary value.
- Uses reverse double-dabble: one shift per clock, so a wide conversion needs no large combinational cone.
- Sits between digit-entry logic and arithmetic datapaths; uses a start/busy/done handshake.

Parameters:
W, 18, binary output width; also the number of shift iterations.
ND, 6, number of BCD digits at the input (4*ND bits).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
bcd_in  input  4*ND  packed digits {most significant ... ones}; nibble 4'hF = blank.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse; bin/ovf/err are valid from this cycle.
bin  output  W  converted value; holds until the next done.
ovf  output  1  value exceeds 2^W-1.
err  output  1  some nibble in range 4'hA..4'hE.

Behaviour:
- Reset (rst_n low, any time, including mid-conversion): state IDLE; busy=0, done=0, bin=0, ovf=0, err=0; internal registers cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE with start=1 at edge E0:
  - Load the digit register from bcd_in, mapping each 4'hF nibble to 0.
  - Latch err_pend = OR over all nibbles of (nibble in A..E).
  - Clear the shift accumulator and the iteration counter; go to SHIFT; busy=1.
- SHIFT, edges E1..EW, one step per edge:
  - Shift the {digits, accumulator} register right by 1; digit LSB enters the accumulator MSB.
  - Then, in the same step, for every digit that is >= 8 after the shift, subtract 3.
  - Increment the counter. After W steps, go to FINISH.
- FINISH, edge E(W+1):
  - done=1 for exactly this one cycle; busy=0; return to IDLE.
  - If err_pend=1: err=1, ovf=0, bin=0.
  - Else if the digit register is nonzero: ovf=1, err=0, bin = all ones (saturate).
  - Else: bin = accumulator, ovf=0, err=0.
- Latency is fixed: done is high in the cycle after edge E(W+1), regardless of input value or error.
- start while busy or in FINISH is ignored; no queuing.
- start may be asserted again in the cycle done is high. The block is then in IDLE, so the request is accepted; back-to-back throughput is one conversion every W+2 cycles.
- bcd_in is only sampled at E0; changes during conversion have no effect.
- A 4'hF nibble in any position is treated as 0, not as an error.
- bin/ovf/err hold their value between done pulses. They are cleared only by reset.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SHIFT, FINISH};
  - BLANK_DIGIT = 4'hF;
  - digit-correction constants (threshold 8, adjust 3);
  - counter-width function clog2(W+1).
- Natural sub-module: bcd_digit_adjust. Combinational, 4-bit in/out, outputs in-3 when in>=8 else in. Instantiated ND times.
- The FSM, counter and shift register stay in bcd2bin_seq.

Test Plan (W=18, ND=6):
- bcd_in=24'h000123, start 1 cycle -> busy for 19 cycles; done pulses at E19 with bin=18'd123, ovf=0, err=0.
- bcd_in=24'hFFFF07 (blanked leading digits) -> bin=7, err=0. bcd_in=24'h262143 -> bin=18'h3FFFF, ovf=0.
- bcd_in=24'h262144 -> ovf=1, bin=18'h3FFFF. bcd_in=24'h999999 -> ovf=1, bin=18'h3FFFF.
- bcd_in=24'h00012A -> err=1, bin=0, ovf=0; done still at E19.
- Pulse start again at E5 with a different bcd_in -> ignored, result is the first input. Then deassert rst_n at E10 -> busy=0, bin=0 immediately. The next start converts normally.
- Round trip: random bin in 0..262143 through the team's binary-to-BCD block (W=18), then through this block -> output equals the original. Include 0 and 262143, and back-to-back starts issued on done.
